// File: rtl/pixel_array_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | pixel_array_ctrl_if : control/status bundle of the pixel frame sequencer |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface pixel_array_ctrl_if #(
    parameter int N     = 2,
    parameter int CNT_W = 8,
    parameter int EXP_W = 16
);
  localparam int NN    = N * N;
  localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;

  logic             start;
  logic             abort;
  logic [EXP_W-1:0] exp_time;
  logic             erase;
  logic             pix_reset;
  logic             expose;
  logic             convert;
  logic [CNT_W-1:0] cnt_out;
  logic             cnt_oe;
  logic [NN-1:0]    read;
  logic             pix_valid;
  logic [IDX_W-1:0] pix_idx;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, abort, exp_time,
    input  erase, pix_reset, expose, convert, cnt_out, cnt_oe,
           read, pix_valid, pix_idx, busy, frame_done
  );

  modport slave (
    input  start, abort, exp_time,
    output erase, pix_reset, expose, convert, cnt_out, cnt_oe,
           read, pix_valid, pix_idx, busy, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/pixel_array_ctrl.sv
// +--------------------------------------------------------------------------+
// | pixel_array_ctrl : erase/expose/convert/readout frame sequencer (Moore)  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module pixel_array_ctrl #(
    parameter int N       = 2,
    parameter int CNT_W   = 8,
    parameter int T_ERASE = 5,
    parameter int T_READ  = 4,
    parameter int EXP_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pixel_array_ctrl_if.slave bus
);
  localparam int c_NN    = N * N;
  localparam int c_IDX_W = (c_NN > 1) ? $clog2(c_NN) : 1;
  localparam int c_PH_W  = $clog2(T_READ);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_ERASE   = 3'd1;
  localparam logic [2:0] c_EXPOSE  = 3'd2;
  localparam logic [2:0] c_CONVERT = 3'd3;
  localparam logic [2:0] c_READOUT = 3'd4;
  localparam logic [2:0] c_DONE    = 3'd5;

  localparam logic [EXP_W-1:0]   c_ERASE_LAST = EXP_W'(T_ERASE - 1);
  localparam logic [c_PH_W-1:0]  c_PH_LAST    = c_PH_W'(T_READ - 1);
  localparam logic [c_IDX_W-1:0] c_PIX_LAST   = c_IDX_W'(c_NN - 1);

  logic [2:0]         r_state;
  logic [EXP_W-1:0]   r_exp;
  logic [EXP_W-1:0]   r_tick;
  logic [CNT_W-1:0]   r_cnt;
  logic [c_PH_W-1:0]  r_phase;
  logic [c_IDX_W-1:0] r_pix;

  logic [EXP_W-1:0]   w_exp_lat;
  logic               w_readout;

  // A zero exposure still spends one cycle in EXPOSE; the tick counter only
  // ever reaches r_exp-1, so the all-ones exposure cannot wrap it.
  assign w_exp_lat = (bus.exp_time == '0) ? EXP_W'(1) : bus.exp_time;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_exp   <= '0;
      r_tick  <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
      r_pix   <= '0;
    end else if (bus.abort) begin
      r_state <= c_IDLE;
      r_tick  <= '0;
      r_cnt   <= '0;
      r_phase <= '0;
      r_pix   <= '0;
    end else begin
      case (r_state)
        c_IDLE, c_DONE: begin
          if (bus.start) begin
            r_state <= c_ERASE;
            r_exp   <= w_exp_lat;
            r_tick  <= '0;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_ERASE: begin
          if (r_tick == c_ERASE_LAST) begin
            r_state <= c_EXPOSE;
            r_tick  <= '0;
          end else begin
            r_tick <= r_tick + EXP_W'(1);
          end
        end
        c_EXPOSE: begin
          if (r_tick == r_exp - EXP_W'(1)) begin
            r_state <= c_CONVERT;
            r_tick  <= '0;
          end else begin
            r_tick <= r_tick + EXP_W'(1);
          end
        end
        c_CONVERT: begin
          // Natural wrap returns the code to 0 on the exit edge.
          r_cnt <= r_cnt + CNT_W'(1);
          if (&r_cnt) begin
            r_state <= c_READOUT;
            r_phase <= '0;
            r_pix   <= '0;
          end
        end
        c_READOUT: begin
          if (r_phase == c_PH_LAST) begin
            r_phase <= '0;
            if (r_pix == c_PIX_LAST) begin
              r_state <= c_DONE;
              r_pix   <= '0;
            end else begin
              r_pix <= r_pix + c_IDX_W'(1);
            end
          end else begin
            r_phase <= r_phase + c_PH_W'(1);
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign w_readout      = (r_state == c_READOUT);

  assign bus.erase      = (r_state == c_ERASE);
  assign bus.pix_reset  = (r_state == c_ERASE);
  assign bus.expose     = (r_state == c_EXPOSE);
  assign bus.convert    = (r_state == c_CONVERT);
  assign bus.cnt_oe     = (r_state == c_CONVERT);
  assign bus.cnt_out    = (r_state == c_CONVERT) ? r_cnt : '0;
  assign bus.read       = w_readout ? (c_NN'(1) << r_pix) : '0;
  assign bus.pix_valid  = w_readout && (r_phase == c_PH_LAST);
  assign bus.pix_idx    = w_readout ? r_pix : '0;
  assign bus.busy       = (r_state != c_IDLE);
  assign bus.frame_done = (r_state == c_DONE);

endmodule

`default_nettype wire

// File: tb/tb_pixel_array_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_pixel_array_ctrl : directed self-checking bench for pixel_array_ctrl  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pixel_array_ctrl;
  localparam int N       = 2;
  localparam int CNT_W   = 8;
  localparam int T_ERASE = 5;
  localparam int T_READ  = 4;
  localparam int EXP_W   = 16;
  localparam int NN      = N * N;
  localparam int LIMIT   = 70000;

  logic clk = 1'b0;
  logic rst_n;

  pixel_array_ctrl_if #(.N(N), .CNT_W(CNT_W), .EXP_W(EXP_W)) bus ();

  pixel_array_ctrl #(
    .N(N), .CNT_W(CNT_W), .T_ERASE(T_ERASE), .T_READ(T_READ), .EXP_W(EXP_W)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Cumulative activity counters, written only by the monitor below.
  int n_erase = 0, n_expose = 0, n_conv = 0, cnt_err = 0;
  int n_rdcyc = 0, rd_err = 0, n_valid = 0, n_done = 0, viol = 0;
  int rd_i = 0, rd_p = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always @(negedge clk) begin
    if (bus.erase) n_erase++;
    if (bus.pix_reset != bus.erase) viol++;
    if (bus.expose) n_expose++;
    if (bus.convert) begin
      if (bus.cnt_out != exp_cnt || !bus.cnt_oe) cnt_err++;
      exp_cnt++;
      n_conv++;
    end else begin
      exp_cnt = '0;
      if (bus.cnt_out != '0 || bus.cnt_oe) viol++;
    end
    if (bus.cnt_oe && |bus.read) viol++;
    if ($countones(bus.read) > 1) viol++;
    if (bus.pix_valid && !bus.read[bus.pix_idx]) viol++;
    if (|bus.read) begin
      rd_p = rd_i / T_READ;
      if (bus.read != (NN'(1) << rd_p) || int'(bus.pix_idx) != rd_p ||
          bus.pix_valid != ((rd_i % T_READ) == T_READ - 1)) rd_err++;
      rd_i++;
      n_rdcyc++;
    end else begin
      rd_i = 0;
      if (bus.pix_valid || bus.pix_idx != '0) viol++;
    end
    if (bus.pix_valid) n_valid++;
    if (bus.frame_done) n_done++;
  end

  int s_erase, s_expose, s_conv, s_cnt_err, s_rdcyc, s_rd_err, s_valid, s_done;

  task automatic snap();
    s_erase = n_erase; s_expose = n_expose; s_conv = n_conv; s_cnt_err = cnt_err;
    s_rdcyc = n_rdcyc; s_rd_err = rd_err;   s_valid = n_valid; s_done = n_done;
  endtask

  // Counts cycles from the START edge until FRAME_DONE is seen (bounded).
  task automatic wait_done(output int n, input bit hold);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!hold) bus.start = 1'b0;
    end while (!bus.frame_done && n < LIMIT);
    #1;
  endtask

  int n, n1, k;

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.exp_time = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_read", bus.read, 0);
    chk("rst_cnt", bus.cnt_out, 0);
    chk("rst_done", bus.frame_done, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rst_idle", bus.busy, 0);

    // Asynchronous reset in the middle of conversion
    bus.exp_time = 16'd10;
    bus.start = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; bus.start = 1'b0; end
    while (bus.cnt_out != 8'h40 && k < 400);
    chk("t1_cnt40", bus.cnt_out, 8'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_conv", bus.convert, 0);
    chk("t1_cnt", bus.cnt_out, 0);
    chk("t1_oe", bus.cnt_oe, 0);
    chk("t1_busy", bus.busy, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk); #1;
    chk("t1_idle", bus.busy, 0);

    // Nominal frame
    snap();
    bus.exp_time = 16'd10;
    bus.start = 1'b1;
    wait_done(n, 1'b0);
    chk("t2_done_cyc", n, 288);
    @(negedge clk); #1;
    chk("t2_idle", bus.busy, 0);
    chk("t2_erase", n_erase - s_erase, 5);
    chk("t2_expose", n_expose - s_expose, 10);
    chk("t2_conv", n_conv - s_conv, 256);
    chk("t2_cnt_seq", cnt_err - s_cnt_err, 0);
    chk("t2_rdcyc", n_rdcyc - s_rdcyc, 16);
    chk("t2_rd_seq", rd_err - s_rd_err, 0);
    chk("t2_valid", n_valid - s_valid, 4);
    chk("t2_ndone", n_done - s_done, 1);

    // Exposure boundaries
    snap();
    bus.exp_time = 16'd0;
    bus.start = 1'b1;
    wait_done(n, 1'b0);
    chk("t3_min_cyc", n, 279);
    chk("t3_min_exp", n_expose - s_expose, 1);
    @(negedge clk); #1;
    snap();
    bus.exp_time = 16'hFFFF;
    bus.start = 1'b1;
    wait_done(n, 1'b0);
    chk("t3_max_cyc", n, 65813);
    chk("t3_max_exp", n_expose - s_expose, 65535);
    @(negedge clk); #1;

    // Back-to-back frames with START held, EXP_TIME changed mid-frame
    snap();
    bus.exp_time = 16'd7;
    bus.start = 1'b1;
    repeat (20) @(negedge clk);
    bus.exp_time = 16'd3;
    wait_done(n, 1'b1);
    n1 = n + 20;
    chk("t4_f1_cyc", n1, 285);
    chk("t4_f1_exp", n_expose - s_expose, 7);
    wait_done(n, 1'b1);
    bus.start = 1'b0;
    chk("t4_f2_cyc", n, 281);
    chk("t4_f2_exp", n_expose - s_expose, 10);
    @(negedge clk); #1;
    chk("t4_idle", bus.busy, 0);
    chk("t4_ndone", n_done - s_done, 2);
    chk("t4_valid", n_valid - s_valid, 8);

    // Abort during readout of pixel 2, then abort+start in IDLE
    bus.exp_time = 16'd10;
    bus.start = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; bus.start = 1'b0; end
    while (bus.read != NN'(4) && k < 400);
    #1;
    chk("t5_pix2", bus.read, 4'b0100);
    snap();
    bus.abort = 1'b1;
    @(negedge clk); #1;
    bus.abort = 1'b0;
    chk("t5_read", bus.read, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_valid", bus.pix_valid, 0);
    repeat (300) @(negedge clk);
    #1;
    chk("t5_nodone", n_done - s_done, 0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk); #1;
    chk("t5_as_busy", bus.busy, 0);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("t5_as_idle", bus.busy, 0);

    chk("invariants", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
